// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among NREQ requesters, with a
// post-reset hold period. Optional grant lock is enabled by defining DFF_ARB_LOCK_EN.
module dff_wr_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  input  logic [NREQ-1:0]         lock,
  output logic [NREQ-1:0]         gnt,
  output logic                    dff_en,
  output logic [WIDTH-1:0]        dff_d,
  output logic                    ready
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 2);

  localparam logic [1:0] StHold  = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StGrant = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [NREQ-1:0]  gnt_d;
  logic             en_d;
  logic [WIDTH-1:0] dd_d;

  logic             arb_valid;
  logic [PW-1:0]    arb_idx;
  logic [PW-1:0]    ptr_inc;

  // First set request at or above ptr, wrapping back to 0.
  always_comb begin
    int unsigned idx;
    arb_valid = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      idx = 32'(ptr_q) + o;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!arb_valid && req[PW'(idx)]) begin
        arb_valid = 1'b1;
        arb_idx   = PW'(idx);
      end
    end
  end

  assign ptr_inc = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt;
    en_d    = dff_en;
    dd_d    = dff_d;
    unique case (state_q)
      StHold: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StIdle: begin
        if (arb_valid) begin
          state_d        = StGrant;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          en_d           = 1'b1;
          dd_d           = din[arb_idx*WIDTH +: WIDTH];
          ptr_d          = ptr_inc;
          win_d          = arb_idx;
        end
      end
      StGrant: begin
`ifdef DFF_ARB_LOCK_EN
        // Locked owner keeps the register; ptr stays where the original grant left it.
        if (lock[win_q] && req[win_q]) begin
          dd_d = din[win_q*WIDTH +: WIDTH];
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
          en_d    = 1'b0;
        end
`else
        state_d = StIdle;
        gnt_d   = '0;
        en_d    = 1'b0;
`endif
      end
      default: state_d = StHold;
    endcase
  end

`ifndef DFF_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHold;
      cnt_q   <= CW'(HOLD_CYCLES);
      ptr_q   <= '0;
      win_q   <= '0;
      gnt     <= '0;
      dff_en  <= 1'b0;
      dff_d   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt     <= gnt_d;
      dff_en  <= en_d;
      dff_d   <= dd_d;
    end
  end

  assign ready = (state_q != StHold);

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Self-checking bench for dff_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of hold period, round-robin pointer and shared-register contents.
module tb_dff_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0]       req  = '0;
  logic [NREQ-1:0]       lock = '0;
  logic [NREQ*WIDTH-1:0] din  = '0;
  logic [NREQ-1:0]       gnt;
  logic                  dff_en;
  logic [WIDTH-1:0]      dff_d;
  logic                  ready;

  dff_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .lock(lock),
    .gnt(gnt), .dff_en(dff_en), .dff_d(dff_d), .ready(ready)
  );

  always #5 clk = ~clk;

  // The shared register the arbiter feeds.
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (dff_en) q <= dff_d;
  end

  int checks = 0;
  int failures = 0;

  // Reference model
  int               hold_left;
  int               m_ptr;
  int               m_win;
  bit               busy;
  logic [NREQ-1:0]  m_gnt;
  logic             m_en;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] m_q;

  function automatic void model_reset();
    hold_left = HOLD + 1;
    m_ptr = 0; m_win = 0; busy = 0;
    m_gnt = '0; m_en = 1'b0; m_d = '0; m_q = '0;
  endfunction

  function automatic void model_edge();
    int w;
    if (m_en) m_q = m_d;
    if (hold_left > 0) begin
      hold_left--;
    end else if (busy) begin
`ifdef DFF_ARB_LOCK_EN
      if (lock[m_win] && req[m_win]) m_d = din[m_win*WIDTH +: WIDTH];
      else begin busy = 0; m_gnt = '0; end
`else
      busy = 0; m_gnt = '0;
`endif
    end else begin
      w = -1;
      for (int o = 0; o < NREQ; o++)
        if (w < 0 && req[(m_ptr + o) % NREQ]) w = (m_ptr + o) % NREQ;
      if (w >= 0) begin
        m_gnt = '0; m_gnt[w] = 1'b1;
        m_d = din[w*WIDTH +: WIDTH];
        m_ptr = (w + 1) % NREQ;
        m_win = w;
        busy = 1;
      end
    end
    m_en = |m_gnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({gnt, dff_en, dff_d, ready} !== '0) begin
      failures++;
      $display("FAIL reset_values got %h required 0", {gnt, dff_en, dff_d, ready});
    end
    req = 4'b1111;
    din = {$urandom};
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if ({gnt, dff_en, dff_d, ready} !== {m_gnt, m_en, m_d, hold_left == 0}) begin
        failures++;
        $display("FAIL hold_model edge %0d got %h required %h", k,
                 {gnt, dff_en, dff_d, ready}, {m_gnt, m_en, m_d, hold_left == 0});
      end
      checks++;
      if (ready !== (k >= 11) || gnt !== ((k == 12) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL hold_timing edge %0d got ready=%b gnt=%b", k, ready, gnt);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] order[$];
    int              when[$];
    logic [NREQ-1:0] exp_order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({gnt, dff_en, dff_d} !== {m_gnt, m_en, m_d}) begin
        failures++;
        $display("FAIL fair_model cyc %0d got %h required %h", k,
                 {gnt, dff_en, dff_d}, {m_gnt, m_en, m_d});
      end
      if (gnt != '0) begin order.push_back(gnt); when.push_back(k); end
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL fair_count got %0d required 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] !== exp_order[i] || when[i] != 2 * i + 1) begin
          failures++;
          $display("FAIL fair_order idx %0d got %b@%0d required %b@%0d", i, order[i], when[i],
                   exp_order[i], 2 * i + 1);
        end
      end
    end
  endtask

  task automatic test_single_write();
    req = '0;
    tick(); tick();
    din = {8'h11, 8'hA5, 8'h22, 8'h33};
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || dff_en !== 1'b1 || dff_d !== 8'hA5) begin
      failures++;
      $display("FAIL single_grant got gnt=%b en=%b d=%h required 0100 1 a5", gnt, dff_en, dff_d);
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || dff_en !== 1'b0 || q !== 8'hA5 || q !== m_q) begin
      failures++;
      $display("FAIL single_capture got gnt=%b en=%b q=%h required 0000 0 a5", gnt, dff_en, q);
    end
  endtask

  task automatic test_pointer_wrap();
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt !== m_gnt) begin
      failures++;
      $display("FAIL wrap_after3 got %b required 0001", gnt);
    end
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt !== m_gnt) begin
      failures++;
      $display("FAIL wrap_after0 got %b required 1000", gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock();
    req  = 4'b0010;
    lock = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      din = {$urandom};
      tick();
      checks++;
      if ({gnt, dff_en, dff_d} !== {m_gnt, m_en, m_d}) begin
        failures++;
        $display("FAIL lock_model cyc %0d got %h required %h", k,
                 {gnt, dff_en, dff_d}, {m_gnt, m_en, m_d});
      end
    end
    req = '0; lock = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req  = NREQ'($urandom);
      lock = NREQ'($urandom);
      din  = {$urandom};
      tick();
      checks++;
      if ({gnt, dff_en, dff_d, ready, q} !== {m_gnt, m_en, m_d, hold_left == 0, m_q}) begin
        failures++;
        $display("FAIL random_model cyc %0d got %h required %h", k,
                 {gnt, dff_en, dff_d, ready, q}, {m_gnt, m_en, m_d, hold_left == 0, m_q});
      end
      checks++;
      if (!$onehot0(gnt) || dff_en !== |gnt) begin
        failures++;
        $display("FAIL random_onehot cyc %0d got gnt=%b en=%b", k, gnt, dff_en);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    req = '0;
    tick(); tick();
    din = {$urandom};
    req = 4'b0100;
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({gnt, dff_en, dff_d, ready} !== '0 || m_gnt !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_async got %h required 0", {gnt, dff_en, dff_d, ready});
    end
    repeat (2) @(negedge clk);
    req = 4'b1111;
    rst = 1'b1;
    for (int k = 1; k <= HOLD + 2; k++) begin
      tick();
      checks++;
      if ({gnt, dff_en, dff_d, ready} !== {m_gnt, m_en, m_d, hold_left == 0}) begin
        failures++;
        $display("FAIL midreset_model edge %0d got %h required %h", k,
                 {gnt, dff_en, dff_d, ready}, {m_gnt, m_en, m_d, hold_left == 0});
      end
    end
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_ptr got %b required 0001", gnt);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_write();
    test_pointer_wrap();
    test_lock();
    test_random();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
